// File: rtl/pulse_trig_pkg.sv
// ============================================================================
// Module : pulse_trig_pkg
// Brief  : Shared FIFO word layout, FSM encodings and helpers for the Pulse
//          Trigger FIFO writer/reader pair. Optional PULSE_TRIG_TS_DELTA_EN
//          adds the W3 (timestamp delta) state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_trig_pkg;

  localparam int TRIG_NUM_W = 24;
  localparam int TS_W       = 44;
  localparam int FIFO_W     = 128;

  // FIFO word: {58'd0, trig_length[1:0], trig_num[23:0], trig_timestamp[43:0]}
  localparam int TS_LSB  = 0;
  localparam int TS_MSB  = 43;
  localparam int NUM_LSB = 44;
  localparam int NUM_MSB = 67;
  localparam int LEN_LSB = 68;
  localparam int LEN_MSB = 69;

  localparam logic [3:0] HDR_TAG_DEF = 4'hC;

  localparam int IDX_IDLE = 0;
  localparam int IDX_W0   = 1;
  localparam int IDX_W1   = 2;
  localparam int IDX_W2   = 3;
  localparam int IDX_W3   = 4;

`ifdef PULSE_TRIG_TS_DELTA_EN
  localparam int ST_W = 5;
`else
  localparam int ST_W = 4;
`endif

  localparam logic [ST_W-1:0] ST_IDLE = ST_W'(1 << IDX_IDLE);
  localparam logic [ST_W-1:0] ST_W0   = ST_W'(1 << IDX_W0);
  localparam logic [ST_W-1:0] ST_W1   = ST_W'(1 << IDX_W1);
  localparam logic [ST_W-1:0] ST_W2   = ST_W'(1 << IDX_W2);
`ifdef PULSE_TRIG_TS_DELTA_EN
  localparam logic [ST_W-1:0] ST_W3   = ST_W'(1 << IDX_W3);
`endif

  // Saturating cur - prev; a backwards step is treated as saturated too.
  function automatic logic [31:0] ts_delta(input logic [TS_W-1:0] cur,
                                           input logic [TS_W-1:0] prev);
    logic [TS_W-1:0] diff;
    diff = cur - prev;
    if (cur < prev) return '1;
    if (diff[TS_W-1:32] != '0) return '1;
    return diff[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_trig_seq_check.sv
// ============================================================================
// Module : pulse_trig_seq_check
// Brief  : Trigger-number continuity tracker with saturating error counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_trig_seq_check
  import pulse_trig_pkg::*;
#(
  parameter int SEQ_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pop_i,
  input  logic [TRIG_NUM_W-1:0] trig_num_i,
  input  logic                  clear_i,
  output logic                  seq_err_o,
  output logic [SEQ_CNT_W-1:0]  err_count_o
);

  logic [TRIG_NUM_W-1:0] expected_q, expected_d;
  logic [SEQ_CNT_W-1:0]  count_q, count_d;
  logic                  w_mismatch;

  always_comb begin
    w_mismatch = pop_i && (trig_num_i != expected_q);
    // A clear wins over the resync, but the popped word still sees the old value.
    expected_d = expected_q;
    if (clear_i)
      expected_d = TRIG_NUM_W'(1);
    else if (pop_i)
      expected_d = trig_num_i + TRIG_NUM_W'(1);
    count_d = count_q;
    if (w_mismatch && (count_q != '1))
      count_d = count_q + SEQ_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_q <= TRIG_NUM_W'(1);
      count_q    <= '0;
    end else begin
      expected_q <= expected_d;
      count_q    <= count_d;
    end
  end

  assign seq_err_o   = w_mismatch;
  assign err_count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pulse_trigger_info_reader.sv
// ============================================================================
// Module : pulse_trigger_info_reader
// Brief  : Pops trigger-info words from the Pulse Trigger FIFO and serializes
//          them into 32-bit valid/ready frames. PULSE_TRIG_TS_DELTA_EN appends
//          a fourth word carrying the saturated timestamp delta.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_trigger_info_reader
  import pulse_trig_pkg::*;
#(
  parameter logic [3:0] HDR_TAG   = HDR_TAG_DEF,
  parameter int         SEQ_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_valid,
  input  logic [FIFO_W-1:0]    fifo_data,
  output logic                 fifo_ready,
  input  logic                 reset_trig_num,
  input  logic                 readout_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_last,
  output logic [SEQ_CNT_W-1:0] seq_err_count,
  output logic [31:0]          frames_sent,
  output logic [ST_W-1:0]      state
);

  logic [ST_W-1:0]       state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [31:0]           out_data_q, out_data_d;
  logic [31:0]           frames_q, frames_d;
  logic [TS_W-1:0]       ts_q, ts_d;

  logic                  w_pop, w_accept, w_clear, w_seq_err;
  logic [1:0]            w_len;
  logic [TRIG_NUM_W-1:0] w_num;
  logic [TS_W-1:0]       w_ts;
  logic                  w_unused_hi;

  assign w_len       = fifo_data[LEN_MSB:LEN_LSB];
  assign w_num       = fifo_data[NUM_MSB:NUM_LSB];
  assign w_ts        = fifo_data[TS_MSB:TS_LSB];
  assign w_unused_hi = ^fifo_data[FIFO_W-1:LEN_MSB+1];
  assign w_pop       = fifo_valid & state_q[IDX_IDLE];
  assign w_accept    = out_valid_q & out_ready;
  assign w_clear     = reset_trig_num | readout_done;

  pulse_trig_seq_check #(
    .SEQ_CNT_W (SEQ_CNT_W)
  ) u_seq_check (
    .clk         (clk),
    .reset       (reset),
    .pop_i       (w_pop),
    .trig_num_i  (w_num),
    .clear_i     (w_clear),
    .seq_err_o   (w_seq_err),
    .err_count_o (seq_err_count)
  );

`ifdef PULSE_TRIG_TS_DELTA_EN
  logic [TS_W-1:0] prev_ts_q, prev_ts_d;
  logic            prev_vld_q, prev_vld_d;
  logic [31:0]     delta_q, delta_d;

  // The first frame after any renumbering reports a zero delta.
  always_comb begin
    prev_ts_d  = prev_ts_q;
    prev_vld_d = prev_vld_q;
    delta_d    = delta_q;
    if (w_pop) begin
      prev_ts_d  = w_ts;
      prev_vld_d = 1'b1;
      delta_d    = prev_vld_q ? ts_delta(w_ts, prev_ts_q) : 32'd0;
    end
    if (w_clear)
      prev_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ts_q  <= '0;
      prev_vld_q <= 1'b0;
      delta_q    <= '0;
    end else begin
      prev_ts_q  <= prev_ts_d;
      prev_vld_q <= prev_vld_d;
      delta_q    <= delta_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    frames_d    = frames_q;
    ts_d        = ts_q;
    case (state_q)
      ST_IDLE: if (w_pop) begin
        state_d     = ST_W0;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        out_data_d  = {HDR_TAG, w_seq_err, 1'b0, w_len, w_num};
        ts_d        = w_ts;
      end
      ST_W0: if (w_accept) begin
        state_d    = ST_W1;
        out_data_d = {20'd0, ts_q[TS_W-1:32]};
      end
      ST_W1: if (w_accept) begin
        state_d    = ST_W2;
        out_data_d = ts_q[31:0];
`ifdef PULSE_TRIG_TS_DELTA_EN
        out_last_d = 1'b0;
`else
        out_last_d = 1'b1;
`endif
      end
      ST_W2: if (w_accept) begin
`ifdef PULSE_TRIG_TS_DELTA_EN
        state_d    = ST_W3;
        out_data_d = delta_q;
        out_last_d = 1'b1;
`else
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        frames_d    = frames_q + 32'd1;
`endif
      end
`ifdef PULSE_TRIG_TS_DELTA_EN
      ST_W3: if (w_accept) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        frames_d    = frames_q + 32'd1;
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frames_q    <= '0;
      ts_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      frames_q    <= frames_d;
      ts_q        <= ts_d;
    end
  end

  assign fifo_ready  = w_pop;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign frames_sent = frames_q;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_trigger_info_reader.sv
// ============================================================================
// Module : tb_pulse_trigger_info_reader
// Brief  : Directed, table-driven bench for pulse_trigger_info_reader.
//          Honors PULSE_TRIG_TS_DELTA_EN (4-word frames with delta word).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_trigger_info_reader;
  import pulse_trig_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              fifo_valid;
  logic [FIFO_W-1:0] fifo_data;
  logic              fifo_ready;
  logic              reset_trig_num;
  logic              readout_done;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic [15:0]       seq_err_count;
  logic [31:0]       frames_sent;
  logic [ST_W-1:0]   state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pulse_trigger_info_reader dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_valid     (fifo_valid),
    .fifo_data      (fifo_data),
    .fifo_ready     (fifo_ready),
    .reset_trig_num (reset_trig_num),
    .readout_done   (readout_done),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .seq_err_count  (seq_err_count),
    .frames_sent    (frames_sent),
    .state          (state)
  );

  typedef struct {
    logic [1:0]  len;
    logic [23:0] num;
    logic [43:0] ts;
    bit          clr;
    logic [31:0] w0, w1, w2, dl;
    logic [31:0] errs;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [FIFO_W-1:0] mk(input logic [1:0] len, input logic [23:0] num,
                                            input logic [43:0] ts);
    return {{29{2'b10}}, len, num, ts};
  endfunction

  task automatic expect_word(input string nm, input logic [31:0] d, input logic l);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      n_total++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", nm);
      return;
    end
    check({nm, "_data"}, out_data, d);
    check({nm, "_last"}, 32'(out_last), 32'(l));
    @(posedge clk); #1;
  endtask

  task automatic tail(input string nm, input logic [31:0] w2, input logic [31:0] dl);
`ifdef PULSE_TRIG_TS_DELTA_EN
    expect_word({nm, "_w2"}, w2, 1'b0);
    expect_word({nm, "_w3"}, dl, 1'b1);
`else
    expect_word({nm, "_w2"}, w2, 1'b1);
    if (dl === 32'hDEAD_0000) $display("note: %s delta word unused", nm);
`endif
  endtask

  task automatic frame(input string nm, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] dl);
    expect_word({nm, "_w0"}, w0, 1'b0);
    expect_word({nm, "_w1"}, w1, 1'b0);
    tail(nm, w2, dl);
  endtask

  task automatic send(input logic [1:0] len, input logic [23:0] num, input logic [43:0] ts,
                      input bit clr_before, input bit clr_at_pop);
    if (clr_before) begin
      reset_trig_num = 1'b1;
      @(posedge clk); #1;
      reset_trig_num = 1'b0;
    end
    fifo_data    = mk(len, num, ts);
    fifo_valid   = 1'b1;
    readout_done = clr_at_pop;
    #1;
    check("fifo_ready_idle", 32'(fifo_ready), 32'd1);
    @(posedge clk); #1;
    fifo_valid   = 1'b0;
    readout_done = 1'b0;
  endtask

  initial begin
    vt[0] = '{2'd1, 24'd1,        44'h00A_0000_0010, 1'b0, 32'hC100_0001, 32'h0000_000A, 32'h0000_0010, 32'h0,         32'd0};
    vt[1] = '{2'd1, 24'd2,        44'h00A_0000_0050, 1'b0, 32'hC100_0002, 32'h0000_000A, 32'h0000_0050, 32'h40,        32'd0};
    vt[2] = '{2'd1, 24'd3,        44'h00A_0000_0090, 1'b0, 32'hC100_0003, 32'h0000_000A, 32'h0000_0090, 32'h40,        32'd0};
    vt[3] = '{2'd2, 24'd1,        44'h0FF_DEAD_BEEF, 1'b1, 32'hC200_0001, 32'h0000_00FF, 32'hDEAD_BEEF, 32'h0,         32'd0};
    vt[4] = '{2'd3, 24'd3,        44'h000_0000_0000, 1'b0, 32'hCB00_0003, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd1};
    vt[5] = '{2'd0, 24'd4,        44'hFFF_FFFF_FFFF, 1'b0, 32'hC000_0004, 32'h0000_0FFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vt[6] = '{2'd1, 24'hFF_FFFF,  44'h000_0000_0001, 1'b0, 32'hC9FF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'd2};
    vt[7] = '{2'd1, 24'd0,        44'h000_0000_0002, 1'b0, 32'hC100_0000, 32'h0000_0000, 32'h0000_0002, 32'h1,         32'd2};

    reset = 1'b1; fifo_valid = 1'b0; fifo_data = '0; reset_trig_num = 1'b0;
    readout_done = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rst_state",     32'(state), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_errs",      32'(seq_err_count), 32'd0);
    check("rst_frames",    frames_sent, 32'd0);
    check("rst_fifo_ready", 32'(fifo_ready), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(vt[i].len, vt[i].num, vt[i].ts, vt[i].clr, 1'b0);
      frame($sformatf("vec%0d", i), vt[i].w0, vt[i].w1, vt[i].w2, vt[i].dl);
      check($sformatf("vec%0d_errs", i), 32'(seq_err_count), vt[i].errs);
      check($sformatf("vec%0d_frames", i), frames_sent, 32'(i + 1));
    end

    // Clear coincident with a pop: checked against the old expectation, then restart at 1.
    send(2'd1, 24'd1, 44'd100, 1'b0, 1'b0);
    frame("coA1", 32'hC100_0001, 32'h0, 32'h0000_0064, 32'h62);
    send(2'd1, 24'd2, 44'd350, 1'b0, 1'b1);
    frame("coA2", 32'hC100_0002, 32'h0, 32'h0000_015E, 32'hFA);
    send(2'd1, 24'd1, 44'h200, 1'b0, 1'b0);
    frame("coA3", 32'hC100_0001, 32'h0, 32'h0000_0200, 32'h0);
    check("coA_errs", 32'(seq_err_count), 32'd2);

    // Backpressure in W1 with another word waiting in the FIFO.
    fifo_data  = mk(2'd1, 24'd2, 44'h00B_0000_0004);
    fifo_valid = 1'b1;
    @(posedge clk); #1;
    fifo_data = mk(2'd1, 24'd3, 44'h00B_0000_0008);
    expect_word("stall_w0", 32'hC100_0002, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_data",  out_data, 32'h0000_000B);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_nopop", 32'(fifo_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    expect_word("stall_w1", 32'h0000_000B, 1'b0);
    tail("stall", 32'h0000_0004, 32'hFFFF_FFFF);
    check("pend_pop", 32'(fifo_ready), 32'd1);
    @(posedge clk); #1;
    fifo_valid = 1'b0;
    frame("pend", 32'hC100_0003, 32'h0000_000B, 32'h0000_0008, 32'h4);
    check("pre_rst_frames", frames_sent, 32'd13);
    check("pre_rst_errs",   32'(seq_err_count), 32'd2);

    // Asynchronous reset in the middle of a frame.
    send(2'd1, 24'd9, 44'h123, 1'b0, 1'b0);
    expect_word("abort_w0", 32'hC900_0009, 1'b0);
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_state",     32'(state), 32'd1);
    check("arst_errs",      32'(seq_err_count), 32'd0);
    check("arst_frames",    frames_sent, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    send(2'd1, 24'd1, 44'd100, 1'b0, 1'b0);
    frame("post1", 32'hC100_0001, 32'h0, 32'h0000_0064, 32'h0);
    send(2'd1, 24'd5, 44'd350, 1'b0, 1'b0);
    frame("post2", 32'hC900_0005, 32'h0, 32'h0000_015E, 32'hFA);
    check("post_errs",   32'(seq_err_count), 32'd1);
    check("post_frames", frames_sent, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
